mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory access controller of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register, and drives a word-wide data bus with a req/ack handshake. It performs byte, half and word loads and stores. It generates the pipeline stall while a bus transfer is outstanding, so the MEM/WB register enable is `~stall_o`. Non-memory instructions pass straight through with no stall.

## Interface
- TIMEOUT, 16: bus cycles to wait for `bus_ack` before aborting; range 2..255.
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- mem_read  in  1  load instruction present (from EX/MEM)
- mem_write  in  1  store instruction present; mem_read and mem_write both 1 is illegal and treated as a load
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- load_signed  in  1  1 = sign-extend byte/half load, 0 = zero-extend
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data, in low bits
- reg_write_in  in  1  writeback enable from EX/MEM
- mem_to_reg_in  in  1  writeback source select from EX/MEM
- rd_in  in  5  destination register
- bus_req  out  1  transfer request, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  32  word address `{addr[31:2],2'b00}`, registered
- bus_be  out  4  byte enables, registered
- bus_wdata  out  32  lane-replicated store data, registered
- bus_ack  in  1  transfer complete; bus_rdata valid this cycle for reads
- bus_rdata  in  32  read word
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM, and hold MEM/WB
- wb_reg_write  out  1  to MEM/WB: reg write enable
- wb_mem_to_reg  out  1  to MEM/WB
- wb_rdata  out  32  to MEM/WB: aligned, extended load data (registered)
- wb_alu  out  32  to MEM/WB: `addr` passed through
- wb_rd  out  5  to MEM/WB
- misalign_o  out  1  one-cycle pulse: misaligned access dropped
- bus_err_o  out  1  one-cycle pulse: bus timeout

## Operation
- `op` = mem_read | mem_write. An access is misaligned when it is a half with `addr[0]=1`, or a word with `addr[1:0]≠0`.
- **IDLE**
  - No op: stall_o=0. Outputs pass through with wb_reg_write = reg_write_in.
  - Op and misaligned: no bus access, stall_o=0, misalign_o=1, wb_reg_write forced 0. The instruction retires as a bubble.
  - Op and aligned: stall_o=1. Load bus_* registers, set bus_req=1, counter=0, and go to BUSY.
- **BUSY**
  - stall_o=1 and bus_req held at 1.
  - On bus_ack: bus_req←0. For a load, latch the extracted data into wb_rdata. Go to DONE.
  - Else, if counter=TIMEOUT-1: bus_req←0, bus_err_o pulse, go to DONE with wb_rdata←0.
  - Else counter+1.
- **DONE**
  - stall_o=0 and the pipeline advances at this edge.
  - wb_reg_write = reg_write_in, except when the transfer timed out, where it is forced 0.
  - Go to IDLE. No new op is accepted in DONE, because EX/MEM still holds the finished instruction.
- Byte enables and store data:
  - byte: be = `0001<<addr[1:0]`, wdata replicated ×4.
  - half: be = 0011 when addr[1]=0, 1100 when addr[1]=1, wdata[15:0] replicated ×2.
  - word: be = 1111.
  - Loads: be=1111, and the lane is selected from bus_rdata by addr[1:0].
- Load extraction (little-endian): select lane `rdata[8*addr[1:0]+:8]` or `rdata[16*addr[1]+:16]`, then extend to 32 bits per load_signed.
- Stores leave wb_rdata unchanged.
- Reset: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, wb_rdata 0, counter 0, bus_err_o 0.
  - stall_o reads 0 while reset is asserted.
  - Reset in BUSY abandons the transfer: bus_req drops the next edge and a late ack is ignored.
- bus_ack outside BUSY is ignored.

## Timing
- Memory op with an ack in the first BUSY cycle, op presented at cycle 0:
  - cycle 0: IDLE, stall=1.
  - cycle 1: BUSY, bus_req=1, ack=1.
  - cycle 2: DONE, stall=0, wb_rdata valid.
  - MEM/WB captures at the end of cycle 2.
  - Minimum 3 cycles per memory op, of which 2 are stall cycles. An ack N cycles late adds N stall cycles.
- Non-memory op and misaligned op: 0 added cycles. misalign_o is combinational in the presenting cycle.
- Timeout: bus_req stays high for exactly TIMEOUT cycles. bus_err_o is high in the DONE cycle.
- Back-to-back memory ops: the second op enters IDLE the cycle after DONE, giving a 3-cycle period.

## Test plan
- **Word load:** addr=0x100, size=10, ack on the first BUSY cycle, bus_rdata=0xDEADBEEF.
  - Required: bus_req high exactly 1 cycle, bus_addr=0x100, stall high for cycles 0–1.
  - In DONE: wb_rdata=0xDEADBEEF, wb_reg_write=1.
- **Signed byte load:** addr=0x103, bus_rdata=0x80112233.
  - Required: wb_rdata=0xFFFFFF80.
  - Same access with load_signed=0: wb_rdata=0x00000080.
- **Half store:** addr=0x22, wdata=0x0000ABCD, ack delayed 3 cycles.
  - Required: bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD.
  - stall is high for 5 cycles; wb_rdata is unchanged.
- **Misaligned word load:** addr=0x41.
  - Required: misalign_o=1 for 1 cycle, no bus_req, stall_o=0, wb_reg_write=0.
- **Timeout:** TIMEOUT=4 and bus_ack never asserted.
  - Required: bus_req high for exactly 4 cycles, bus_err_o pulses once, wb_rdata=0, wb_reg_write=0.
  - The next op proceeds normally.
- **Reset mid-transfer:** assert reset in the second BUSY cycle, then drive bus_ack 1 cycle later.
  - Required: all outputs at their reset values, state IDLE, the late ack has no effect, and the following load completes correctly.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory bus between the MEM-stage access unit (master) and memory (slave).
// Handshake: the master raises bus_req with bus_we/bus_addr/bus_be/bus_wdata stable and holds
// them until the slave pulses bus_ack for one cycle; bus_rdata is valid only in that ack cycle.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: byte/half/word loads and stores over a req/ack bus,
// stalling the pipeline while a transfer is outstanding and aborting after TIMEOUT bus cycles.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic [4:0]  rd_in,
  mem_access_unit_if.master bus,
  output logic        stall_o,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [31:0] wb_rdata,
  output logic [31:0] wb_alu,
  output logic [4:0]  wb_rd,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        op;
  logic        misaligned;
  logic        access_ok;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  always_comb begin
    op         = mem_read | mem_write;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (size)
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        be_next    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata[15:0]}};
      end
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
    // A load (including the illegal read+write combination) always fetches the full word.
    if (mem_read) be_next = 4'b1111;
    access_ok = op & ~misaligned;

    lane_b = bus.bus_rdata[{addr[1:0], 3'b000} +: 8];
    lane_h = bus.bus_rdata[{addr[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_data = {{24{load_signed & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{load_signed & lane_h[15]}}, lane_h};
      default: load_data = bus.bus_rdata;
    endcase
  end

  always_comb begin
    stall_o    = ~reset & (((state == IDLE) & access_ok) | (state == BUSY));
    misalign_o = ~reset & (state == IDLE) & op & misaligned;
    wb_reg_write = reg_write_in;
    if ((state == IDLE) && op && misaligned) wb_reg_write = 1'b0;
    // bus_err_o is high exactly in the DONE cycle of an aborted transfer.
    if ((state == DONE) && bus_err_o) wb_reg_write = 1'b0;
  end

  assign wb_mem_to_reg = mem_to_reg_in;
  assign wb_alu        = addr;
  assign wb_rd         = rd_in;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_be    <= 4'd0;
      bus.bus_wdata <= 32'd0;
      wb_rdata      <= 32'd0;
      bus_err_o     <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (access_ok) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= mem_write & ~mem_read;
            bus.bus_addr  <= {addr[31:2], 2'b00};
            bus.bus_be    <= be_next;
            bus.bus_wdata <= wdata_next;
            cnt           <= 8'd0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) wb_rdata <= load_data;
            state <= DONE;
          end else if (cnt == LAST_CNT) begin
            bus.bus_req <= 1'b0;
            bus_err_o   <= 1'b1;
            wb_rdata    <= 32'd0;
            state       <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads/stores of each size, delayed ack, misalignment,
// bus timeout and reset during a transfer, with hand-computed expectations.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic [4:0]  rd_in;
  logic        stall_o;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [31:0] wb_rdata;
  logic [31:0] wb_alu;
  logic [4:0]  wb_rd;
  logic        misalign_o;
  logic        bus_err_o;
  logic [1:0]  state_dbg;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Per-access observations gathered by run_access.
  int          r_stall_n;
  int          r_req_n;
  int          r_err_n;
  logic        r_done_seen;
  logic [31:0] r_done_rdata;
  logic        r_done_wbrw;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_addr;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .size          (size),
    .load_signed   (load_signed),
    .addr          (addr),
    .wdata         (wdata),
    .reg_write_in  (reg_write_in),
    .mem_to_reg_in (mem_to_reg_in),
    .rd_in         (rd_in),
    .bus           (bus),
    .stall_o       (stall_o),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_rdata      (wb_rdata),
    .wb_alu        (wb_alu),
    .wb_rd         (wb_rd),
    .misalign_o    (misalign_o),
    .bus_err_o     (bus_err_o),
    .state_dbg     (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    size          = 2'b00;
    load_signed   = 1'b0;
    addr          = 32'd0;
    wdata         = 32'd0;
    reg_write_in  = 1'b0;
    mem_to_reg_in = 1'b0;
    rd_in         = 5'd0;
  endtask

  // Presents one memory op (called at a falling edge), acks on BUSY cycle ack_delay
  // (never if negative), and returns at the falling edge after DONE with inputs idle.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                            input int ack_delay);
    int busy_n;
    mem_read      = rd;
    mem_write     = wr;
    size          = sz;
    load_signed   = sgn;
    addr          = a;
    wdata         = wd;
    reg_write_in  = 1'b1;
    mem_to_reg_in = rd;
    rd_in         = 5'd7;
    r_stall_n     = 0;
    r_req_n       = 0;
    r_err_n       = 0;
    r_done_seen   = 1'b0;
    r_done_rdata  = 32'd0;
    r_done_wbrw   = 1'b0;
    busy_n        = 0;
    for (int cyc = 0; cyc < 40 && !r_done_seen; cyc++) begin
      #2;
      if (stall_o) r_stall_n++;
      if (bus_err_o) r_err_n++;
      if (bus.bus_req) begin
        r_req_n++;
        r_we    = bus.bus_we;
        r_be    = bus.bus_be;
        r_wdata = bus.bus_wdata;
        r_addr  = bus.bus_addr;
      end
      if (state_dbg == 2'd2) begin
        r_done_seen  = 1'b1;
        r_done_rdata = wb_rdata;
        r_done_wbrw  = wb_reg_write;
      end
      @(negedge clk);
      bus.bus_ack   = 1'b0;
      bus.bus_rdata = 32'h5A5A5A5A;
      if (r_done_seen) idle_inputs();
      else if (state_dbg == 2'd1) begin
        if (ack_delay >= 0 && busy_n == ack_delay) begin
          bus.bus_ack   = 1'b1;
          bus.bus_rdata = rdat;
        end
        busy_n++;
      end
    end
    check("done_reached", {31'd0, r_done_seen}, 32'd1);
    if (!r_done_seen) idle_inputs();
  endtask

  initial begin
    idle_inputs();
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'h5A5A5A5A;
    reset         = 1'b1;
    // An aligned op presented during reset must not raise stall.
    mem_read = 1'b1;
    size     = 2'b10;
    addr     = 32'h100;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("rst_state",     {30'd0, state_dbg}, 32'd0);
    check("rst_bus_req",   {31'd0, bus.bus_req}, 32'd0);
    check("rst_bus_we",    {31'd0, bus.bus_we}, 32'd0);
    check("rst_bus_addr",  bus.bus_addr, 32'd0);
    check("rst_bus_be",    {28'd0, bus.bus_be}, 32'd0);
    check("rst_bus_wdata", bus.bus_wdata, 32'd0);
    check("rst_wb_rdata",  wb_rdata, 32'd0);
    check("rst_bus_err",   {31'd0, bus_err_o}, 32'd0);
    check("rst_stall",     {31'd0, stall_o}, 32'd0);

    // Non-memory instruction passes straight through.
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    reg_write_in  = 1'b1;
    mem_to_reg_in = 1'b0;
    addr          = 32'h1234;
    rd_in         = 5'd9;
    #2;
    check("pass_stall",    {31'd0, stall_o}, 32'd0);
    check("pass_wbrw",     {31'd0, wb_reg_write}, 32'd1);
    check("pass_alu",      wb_alu, 32'h1234);
    check("pass_rd",       {27'd0, wb_rd}, 32'd9);
    check("pass_misalign", {31'd0, misalign_o}, 32'd0);
    @(negedge clk);

    // Word load, ack on first BUSY cycle.
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 0);
    check("wl_stall_cycles", r_stall_n, 32'd2);
    check("wl_req_cycles",   r_req_n, 32'd1);
    check("wl_addr",         r_addr, 32'h100);
    check("wl_we",           {31'd0, r_we}, 32'd0);
    check("wl_be",           {28'd0, r_be}, 32'hF);
    check("wl_rdata",        r_done_rdata, 32'hDEADBEEF);
    check("wl_wbrw",         {31'd0, r_done_wbrw}, 32'd1);
    check("wl_err",          r_err_n, 32'd0);

    // Signed then unsigned byte load from the top lane.
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 32'h80112233, 0);
    check("sb_rdata", r_done_rdata, 32'hFFFFFF80);
    check("sb_addr",  r_addr, 32'h100);
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 32'h80112233, 0);
    check("ub_rdata", r_done_rdata, 32'h00000080);

    // Half store, upper half, ack 3 cycles late.
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'h0, 3);
    check("hs_we",           {31'd0, r_we}, 32'd1);
    check("hs_be",           {28'd0, r_be}, 32'hC);
    check("hs_wdata",        r_wdata, 32'hABCDABCD);
    check("hs_addr",         r_addr, 32'h20);
    check("hs_stall_cycles", r_stall_n, 32'd5);
    check("hs_req_cycles",   r_req_n, 32'd4);
    check("hs_rdata_kept",   r_done_rdata, 32'h00000080);

    // Misaligned word load retires as a bubble.
    mem_read     = 1'b1;
    size         = 2'b10;
    addr         = 32'h41;
    reg_write_in = 1'b1;
    #2;
    check("mis_pulse", {31'd0, misalign_o}, 32'd1);
    check("mis_stall", {31'd0, stall_o}, 32'd0);
    check("mis_wbrw",  {31'd0, wb_reg_write}, 32'd0);
    check("mis_req",   {31'd0, bus.bus_req}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #2;
    check("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
    check("mis_req_after", {31'd0, bus.bus_req}, 32'd0);
    check("mis_state",     {30'd0, state_dbg}, 32'd0);
    @(negedge clk);

    // Timeout: no ack at all with TIMEOUT=4.
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'd0, 32'h0, -1);
    check("to_req_cycles",   r_req_n, 32'd4);
    check("to_stall_cycles", r_stall_n, 32'd5);
    check("to_err_pulses",   r_err_n, 32'd1);
    check("to_rdata",        r_done_rdata, 32'd0);
    check("to_wbrw",         {31'd0, r_done_wbrw}, 32'd0);

    // Next op after a timeout: signed half load from upper half, ack 1 late.
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h46, 32'd0, 32'h9ABC1234, 1);
    check("nx_rdata",        r_done_rdata, 32'hFFFF9ABC);
    check("nx_stall_cycles", r_stall_n, 32'd3);
    check("nx_err",          r_err_n, 32'd0);
    check("nx_wbrw",         {31'd0, r_done_wbrw}, 32'd1);

    // Reset in the second BUSY cycle, late ack afterwards.
    mem_read     = 1'b1;
    size         = 2'b10;
    addr         = 32'h300;
    reg_write_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("mr_busy_before", {30'd0, state_dbg}, 32'd1);
    check("mr_stall_in_rst", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = 32'hFFFFFFFF;
    #2;
    check("mr_state",    {30'd0, state_dbg}, 32'd0);
    check("mr_req",      {31'd0, bus.bus_req}, 32'd0);
    check("mr_we",       {31'd0, bus.bus_we}, 32'd0);
    check("mr_addr",     bus.bus_addr, 32'd0);
    check("mr_be",       {28'd0, bus.bus_be}, 32'd0);
    check("mr_wdata",    bus.bus_wdata, 32'd0);
    check("mr_wb_rdata", wb_rdata, 32'd0);
    check("mr_err",      {31'd0, bus_err_o}, 32'd0);
    @(negedge clk);
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'h5A5A5A5A;
    #2;
    check("mr_late_ack_state", {30'd0, state_dbg}, 32'd0);
    check("mr_late_ack_rdata", wb_rdata, 32'd0);
    check("mr_late_ack_err",   {31'd0, bus_err_o}, 32'd0);
    @(negedge clk);
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h302, 32'd0, 32'h00AB0000, 0);
    check("mr_next_rdata", r_done_rdata, 32'hFFFFFFAB);
    check("mr_next_addr",  r_addr, 32'h300);
    check("mr_next_stall", r_stall_n, 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
